// File: rtl/instr_register_calc.sv
// -----------------------------------------------------------------------------
// instr_register_calc
//
// Parametrised instruction register with an integrated ALU. Each of the DEPTH
// entries stores an opcode, two signed operands, the signed result of applying
// the opcode to them, a divide-by-zero flag and a "written since reset" flag.
//
// Writes flow through two stages:
//   stage 1 (capture)        : pointer, opcode and operands are registered.
//   stage 2 (execute/commit) : the ALU result is computed from stage 1 and
//                              committed to the entry on the next posedge.
// Reads are registered and appear one cycle after read_en is sampled. A read
// sampled on the same edge as a commit to the same entry sees the old data;
// there is deliberately no bypass path.
//
// Ports:
//   clk            in   clock, all state updates on posedge
//   reset          in   asynchronous active-high reset, clears all state
//   load_en        in   write request
//   write_pointer  in   target entry of the write
//   opcode         in   ZERO/PASSA/PASSB/ADD/SUB/MULT/DIV/MOD (3 bits)
//   operand_a      in   signed operand a
//   operand_b      in   signed operand b
//   read_en        in   read request
//   read_pointer   in   entry to read
//   rd_valid       out  one-cycle pulse, read data valid
//   rd_written     out  entry has been written since reset
//   rd_opcode      out  stored opcode
//   rd_operand_a   out  stored operand a
//   rd_operand_b   out  stored operand b
//   rd_result      out  stored signed result (2*OP_WIDTH)
//   rd_err         out  stored divide-by-zero flag
//   wr_count       out  number of distinct entries written (saturates at DEPTH)
// -----------------------------------------------------------------------------
module instr_register_calc #(
    parameter int DEPTH      = 32,
    parameter int OP_WIDTH   = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_en,
    input  logic [ADDR_WIDTH-1:0]        write_pointer,
    input  logic [2:0]                   opcode,
    input  logic signed [OP_WIDTH-1:0]   operand_a,
    input  logic signed [OP_WIDTH-1:0]   operand_b,
    input  logic                         read_en,
    input  logic [ADDR_WIDTH-1:0]        read_pointer,
    output logic                         rd_valid,
    output logic                         rd_written,
    output logic [2:0]                   rd_opcode,
    output logic signed [OP_WIDTH-1:0]   rd_operand_a,
    output logic signed [OP_WIDTH-1:0]   rd_operand_b,
    output logic signed [2*OP_WIDTH-1:0] rd_result,
    output logic                         rd_err,
    output logic [ADDR_WIDTH:0]          wr_count
);

    localparam int                    RES_WIDTH = 2 * OP_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    // ALU: returns {err, result}. Operands are sign-extended to the result
    // width first, so every operation (including the product) is exact.
    // SystemVerilog signed division truncates toward zero and the remainder
    // follows the sign of the dividend, which is the required semantics.
    function automatic logic [RES_WIDTH:0] alu_f(
        input logic [2:0]                 op,
        input logic signed [OP_WIDTH-1:0] a,
        input logic signed [OP_WIDTH-1:0] b
    );
        logic signed [RES_WIDTH-1:0] a_x;
        logic signed [RES_WIDTH-1:0] b_x;
        logic signed [RES_WIDTH-1:0] res;
        logic                        err;
        a_x = {{OP_WIDTH{a[OP_WIDTH-1]}}, a};
        b_x = {{OP_WIDTH{b[OP_WIDTH-1]}}, b};
        res = {RES_WIDTH{1'b0}};
        err = 1'b0;
        case (op)
            ZERO:    res = {RES_WIDTH{1'b0}};
            PASSA:   res = a_x;
            PASSB:   res = b_x;
            ADD:     res = a_x + b_x;
            SUB:     res = a_x - b_x;
            MULT:    res = a_x * b_x;
            DIV: begin
                if (b_x == {RES_WIDTH{1'b0}}) begin
                    err = 1'b1;
                    res = {RES_WIDTH{1'b0}};
                end else begin
                    res = a_x / b_x;
                end
            end
            MOD: begin
                if (b_x == {RES_WIDTH{1'b0}}) begin
                    err = 1'b1;
                    res = {RES_WIDTH{1'b0}};
                end else begin
                    res = a_x % b_x;
                end
            end
            default: res = {RES_WIDTH{1'b0}};
        endcase
        return {err, res};
    endfunction

    // Stage-1 (capture) registers
    logic                         s1_valid_r;
    logic [ADDR_WIDTH-1:0]        s1_ptr_r;
    logic [2:0]                   s1_opcode_r;
    logic signed [OP_WIDTH-1:0]   s1_a_r;
    logic signed [OP_WIDTH-1:0]   s1_b_r;

    // Entry storage
    logic [2:0]                   mem_opcode_r [DEPTH];
    logic signed [OP_WIDTH-1:0]   mem_a_r      [DEPTH];
    logic signed [OP_WIDTH-1:0]   mem_b_r      [DEPTH];
    logic signed [RES_WIDTH-1:0]  mem_result_r [DEPTH];
    logic [DEPTH-1:0]             mem_err_r;
    logic [DEPTH-1:0]             mem_written_r;
    logic [ADDR_WIDTH:0]          wr_count_r;

    // Read output registers
    logic                         rd_valid_r;
    logic                         rd_written_r;
    logic [2:0]                   rd_opcode_r;
    logic signed [OP_WIDTH-1:0]   rd_operand_a_r;
    logic signed [OP_WIDTH-1:0]   rd_operand_b_r;
    logic signed [RES_WIDTH-1:0]  rd_result_r;
    logic                         rd_err_r;

    // Execute-stage combinational results
    logic [RES_WIDTH:0]           alu_out_s;
    logic signed [RES_WIDTH-1:0]  commit_result_s;
    logic                         commit_err_s;
    logic                         commit_new_s;
    logic                         wr_in_range_s;
    logic                         rd_in_range_s;

    // Pointer range checks only matter when DEPTH leaves unused pointer codes.
    generate
        if (DEPTH == (1 << ADDR_WIDTH)) begin : g_full_range
            assign wr_in_range_s = 1'b1;
            assign rd_in_range_s = 1'b1;
        end else begin : g_partial_range
            assign wr_in_range_s = ({1'b0, write_pointer} < DEPTH_CNT);
            assign rd_in_range_s = ({1'b0, read_pointer}  < DEPTH_CNT);
        end
    endgenerate

    // Execute: evaluate the ALU on the captured instruction.
    always_comb begin
        alu_out_s       = alu_f(s1_opcode_r, s1_a_r, s1_b_r);
        commit_err_s    = alu_out_s[RES_WIDTH];
        commit_result_s = alu_out_s[RES_WIDTH-1:0];
    end

    // A commit counts as new only if the target entry had never been written.
    always_comb begin
        if (s1_valid_r) begin
            commit_new_s = ~mem_written_r[s1_ptr_r];
        end else begin
            commit_new_s = 1'b0;
        end
    end

    // Stage 1: capture in-range write requests; out-of-range writes are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_r  <= 1'b0;
            s1_ptr_r    <= {ADDR_WIDTH{1'b0}};
            s1_opcode_r <= 3'd0;
            s1_a_r      <= {OP_WIDTH{1'b0}};
            s1_b_r      <= {OP_WIDTH{1'b0}};
        end else if (load_en && wr_in_range_s) begin
            s1_valid_r  <= 1'b1;
            s1_ptr_r    <= write_pointer;
            s1_opcode_r <= opcode;
            s1_a_r      <= operand_a;
            s1_b_r      <= operand_b;
        end else begin
            s1_valid_r  <= 1'b0;
        end
    end

    // Stage 2: commit the executed instruction into its entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_opcode_r[i] <= 3'd0;
                mem_a_r[i]      <= {OP_WIDTH{1'b0}};
                mem_b_r[i]      <= {OP_WIDTH{1'b0}};
                mem_result_r[i] <= {RES_WIDTH{1'b0}};
            end
            mem_err_r     <= {DEPTH{1'b0}};
            mem_written_r <= {DEPTH{1'b0}};
        end else if (s1_valid_r) begin
            mem_opcode_r[s1_ptr_r]  <= s1_opcode_r;
            mem_a_r[s1_ptr_r]       <= s1_a_r;
            mem_b_r[s1_ptr_r]       <= s1_b_r;
            mem_result_r[s1_ptr_r]  <= commit_result_s;
            mem_err_r[s1_ptr_r]     <= commit_err_s;
            mem_written_r[s1_ptr_r] <= 1'b1;
        end
    end

    // Distinct-entry counter; saturates at DEPTH as a safety net.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_count_r <= {(ADDR_WIDTH + 1){1'b0}};
        end else if (commit_new_s && (wr_count_r < DEPTH_CNT)) begin
            wr_count_r <= wr_count_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
        end
    end

    // Registered read port. Storage is sampled before this edge's commit
    // lands, so a same-edge read of the committing entry returns old data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_r     <= 1'b0;
            rd_written_r   <= 1'b0;
            rd_opcode_r    <= 3'd0;
            rd_operand_a_r <= {OP_WIDTH{1'b0}};
            rd_operand_b_r <= {OP_WIDTH{1'b0}};
            rd_result_r    <= {RES_WIDTH{1'b0}};
            rd_err_r       <= 1'b0;
        end else if (read_en) begin
            rd_valid_r <= 1'b1;
            if (rd_in_range_s) begin
                rd_written_r   <= mem_written_r[read_pointer];
                rd_opcode_r    <= mem_opcode_r[read_pointer];
                rd_operand_a_r <= mem_a_r[read_pointer];
                rd_operand_b_r <= mem_b_r[read_pointer];
                rd_result_r    <= mem_result_r[read_pointer];
                rd_err_r       <= mem_err_r[read_pointer];
            end else begin
                rd_written_r   <= 1'b0;
                rd_opcode_r    <= 3'd0;
                rd_operand_a_r <= {OP_WIDTH{1'b0}};
                rd_operand_b_r <= {OP_WIDTH{1'b0}};
                rd_result_r    <= {RES_WIDTH{1'b0}};
                rd_err_r       <= 1'b0;
            end
        end else begin
            rd_valid_r <= 1'b0;
        end
    end

    assign rd_valid     = rd_valid_r;
    assign rd_written   = rd_written_r;
    assign rd_opcode    = rd_opcode_r;
    assign rd_operand_a = rd_operand_a_r;
    assign rd_operand_b = rd_operand_b_r;
    assign rd_result    = rd_result_r;
    assign rd_err       = rd_err_r;
    assign wr_count     = wr_count_r;

    instr_register_calc_chk #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_chk (
        .clk      (clk),
        .reset    (reset),
        .written  (mem_written_r),
        .wr_count (wr_count_r)
    );

endmodule

// -----------------------------------------------------------------------------
// instr_register_calc_chk
//
// Invariant checker for instr_register_calc: the distinct-write counter must
// always equal the number of set written flags and never exceed DEPTH.
//
// Ports:
//   clk       in  clock
//   reset     in  asynchronous active-high reset
//   written   in  per-entry written flags
//   wr_count  in  distinct-entry counter
// -----------------------------------------------------------------------------
module instr_register_calc_chk #(
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input logic                  clk,
    input logic                  reset,
    input logic [DEPTH-1:0]      written,
    input logic [ADDR_WIDTH:0]   wr_count
);

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    // Population count of the written flags.
    function automatic logic [ADDR_WIDTH:0] popcount_f(input logic [DEPTH-1:0] v);
        logic [ADDR_WIDTH:0] n;
        n = {(ADDR_WIDTH + 1){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            n = n + {{ADDR_WIDTH{1'b0}}, v[i]};
        end
        return n;
    endfunction

    logic [ADDR_WIDTH:0] pop_s;

    // Reference count derived from the flags themselves.
    always_comb begin
        pop_s = popcount_f(written);
    end

    a_count_matches_flags: assert property (
        @(posedge clk) disable iff (reset) (wr_count == pop_s));

    a_count_bounded: assert property (
        @(posedge clk) disable iff (reset) (wr_count <= DEPTH_CNT));

endmodule

// File: tb/tb_instr_register_calc.sv
// -----------------------------------------------------------------------------
// tb_instr_register_calc
//
// Scoreboard bench for instr_register_calc with DEPTH=20, OP_WIDTH=8.
// The driver issues directed write/read vectors whose results were worked out
// by hand; every read pushes its expected record into a queue. A separate
// monitor pops and compares whenever rd_valid is seen on the falling edge.
// -----------------------------------------------------------------------------
module tb_instr_register_calc;

    localparam int DEPTH = 20;
    localparam int OPW   = 8;
    localparam int AW    = 5;

    localparam logic [2:0] ZERO  = 3'd0;
    localparam logic [2:0] PASSA = 3'd1;
    localparam logic [2:0] PASSB = 3'd2;
    localparam logic [2:0] ADD   = 3'd3;
    localparam logic [2:0] SUB   = 3'd4;
    localparam logic [2:0] MULT  = 3'd5;
    localparam logic [2:0] DIV   = 3'd6;
    localparam logic [2:0] MOD   = 3'd7;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_en;
    logic [AW-1:0]     write_pointer;
    logic [2:0]        opcode;
    logic [OPW-1:0]    operand_a;
    logic [OPW-1:0]    operand_b;
    logic              read_en;
    logic [AW-1:0]     read_pointer;
    logic              rd_valid;
    logic              rd_written;
    logic [2:0]        rd_opcode;
    logic [OPW-1:0]    rd_operand_a;
    logic [OPW-1:0]    rd_operand_b;
    logic [2*OPW-1:0]  rd_result;
    logic              rd_err;
    logic [AW:0]       wr_count;

    instr_register_calc #(
        .DEPTH    (DEPTH),
        .OP_WIDTH (OPW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .load_en       (load_en),
        .write_pointer (write_pointer),
        .opcode        (opcode),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .read_en       (read_en),
        .read_pointer  (read_pointer),
        .rd_valid      (rd_valid),
        .rd_written    (rd_written),
        .rd_opcode     (rd_opcode),
        .rd_operand_a  (rd_operand_a),
        .rd_operand_b  (rd_operand_b),
        .rd_result     (rd_result),
        .rd_err        (rd_err),
        .wr_count      (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          written;
        logic [2:0]    op;
        logic [7:0]    a;
        logic [7:0]    b;
        logic [15:0]   res;
        logic          err;
        logic [5:0]    cnt;
    } rec_t;

    rec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model of stored entries (results are hand-supplied).
    bit          m_wr  [DEPTH];
    logic [2:0]  m_op  [DEPTH];
    logic [7:0]  m_a   [DEPTH];
    logic [7:0]  m_b   [DEPTH];
    logic [15:0] m_res [DEPTH];
    bit          m_err [DEPTH];
    int          m_cnt;
    bit          p_v;
    int          p_ptr;
    logic [2:0]  p_op;
    logic [7:0]  p_a, p_b;
    logic [15:0] p_res;
    bit          p_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_wr[i] = 1'b0; m_op[i] = 3'd0; m_a[i] = 8'd0; m_b[i] = 8'd0;
            m_res[i] = 16'd0; m_err[i] = 1'b0;
        end
        m_cnt = 0;
        p_v   = 1'b0;
        exp_q.delete();
    endtask

    // One clock cycle: drive inputs, advance the model across the edge.
    task automatic cycle(input bit ld, input int wp, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] er, input bit ee,
                         input bit rd, input int rp);
        rec_t e;
        load_en       = ld;
        write_pointer = wp[AW-1:0];
        opcode        = op;
        operand_a     = a;
        operand_b     = b;
        read_en       = rd;
        read_pointer  = rp[AW-1:0];
        e = '0;
        // read samples storage before this edge's commit
        if (rd && rp < DEPTH) begin
            e.written = m_wr[rp]; e.op = m_op[rp]; e.a = m_a[rp];
            e.b = m_b[rp]; e.res = m_res[rp]; e.err = m_err[rp];
        end
        if (p_v) begin
            if (!m_wr[p_ptr]) m_cnt++;
            m_wr[p_ptr] = 1'b1; m_op[p_ptr] = p_op; m_a[p_ptr] = p_a;
            m_b[p_ptr] = p_b; m_res[p_ptr] = p_res; m_err[p_ptr] = p_err;
        end
        if (rd) begin
            e.cnt = m_cnt[5:0];
            exp_q.push_back(e);
        end
        p_v = ld && (wp < DEPTH);
        p_ptr = wp; p_op = op; p_a = a; p_b = b; p_res = er; p_err = ee;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int wp, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [15:0] er, input bit ee);
        cycle(1'b1, wp, op, a, b, er, ee, 1'b0, 0);
    endtask

    task automatic rd(input int rp);
        cycle(1'b0, 0, 3'd0, 8'd0, 8'd0, 16'd0, 1'b0, 1'b1, rp);
    endtask

    task automatic idle();
        cycle(1'b0, 0, 3'd0, 8'd0, 8'd0, 16'd0, 1'b0, 1'b0, 0);
    endtask

    // Monitor: compare every presented read against the scoreboard head.
    initial begin
        rec_t e;
        rec_t act;
        forever begin
            @(negedge clk);
            if (rd_valid === 1'b1) begin
                act = {rd_written, rd_opcode, rd_operand_a, rd_operand_b,
                       rd_result, rd_err, wr_count};
                if (exp_q.size() == 0) begin
                    check("unexpected_rd_valid", 64'(act), 64'h7FF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_record", 64'(act), 64'(e));
                end
            end
        end
    end

    // Stimulus
    initial begin
        reset = 1'b1;
        load_en = 1'b0; write_pointer = '0; opcode = 3'd0;
        operand_a = 8'd0; operand_b = 8'd0; read_en = 1'b0; read_pointer = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_rd_valid", 64'(rd_valid), 64'd0);
        check("reset_wr_count", 64'(wr_count), 64'd0);
        reset = 1'b0;

        rd(5);                                          // all zeros after reset

        wr(0, ADD,  8'hF1, 8'h07, 16'hFFF8, 1'b0);      // -15 + 7 = -8
        wr(1, MULT, 8'h80, 8'h80, 16'h4000, 1'b0);      // -128 * -128 = 16384
        wr(2, SUB,  8'd5,  8'd12, 16'hFFF9, 1'b0);      // 5 - 12 = -7
        idle();
        rd(0); rd(1); rd(2);

        // write 3 alongside an independent read of entry 0
        cycle(1'b1, 3, DIV, 8'hF9, 8'h02, 16'hFFFD, 1'b0, 1'b1, 0);  // -7/2 = -3
        wr(4, MOD, 8'hF9, 8'h02, 16'hFFFF, 1'b0);       // -7 % 2 = -1
        wr(5, DIV, 8'd9,  8'd0,  16'h0000, 1'b1);       // divide by zero
        idle();
        rd(3); rd(4); rd(5);

        // commit/read hazard on entry 6
        wr(6, PASSA, 8'd1, 8'd0, 16'd1, 1'b0);
        idle(); idle();
        wr(6, PASSA, 8'd42, 8'd3, 16'd42, 1'b0);
        rd(6);                                          // same edge as commit: old
        rd(6);                                          // new data, count unchanged

        wr(7, PASSB, 8'd3, 8'hF7, 16'hFFF7, 1'b0);      // b = -9
        wr(8, ZERO,  8'd5, 8'd5,  16'h0000, 1'b0);
        idle();
        rd(7); rd(8);

        // out-of-range pointer
        wr(25, ADD, 8'd1, 8'd1, 16'd2, 1'b0);
        idle();
        rd(25);

        // reset while a write sits in stage 1 and a read response is pending
        cycle(1'b1, 9, ADD, 8'd1, 8'd2, 16'd3, 1'b0, 1'b1, 0);
        reset = 1'b1;
        load_en = 1'b0; read_en = 1'b0;
        model_reset();
        #2;
        check("midreset_rd_valid", 64'(rd_valid), 64'd0);
        check("midreset_wr_count", 64'(wr_count), 64'd0);
        reset = 1'b0;
        rd(9); rd(0);

        // fill every entry twice; count must saturate at DEPTH
        for (int i = 0; i < DEPTH; i++) begin
            wr(i, ADD, i[7:0], 8'd1, 16'(i + 1), 1'b0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            wr(i, ADD, i[7:0], 8'd2, 16'(i + 2), 1'b0);
        end
        idle();
        rd(0); rd(19); rd(10);

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) idle();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
